// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the register-file writeback path.
//   XLEN      - datapath width
//   NREG      - architectural register count
//   reg_idx_t - register select
//   wb_req_t  - one writeback request {rd, data}
//   REQ_EXEC / REQ_MEM - requester indices on the shared write port
package core_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    localparam int REQ_EXEC = 0;
    localparam int REQ_MEM  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst - clock, synchronous active-high reset
//   req[1:0] - request lines
//   gnt[1:0] - one-hot grant, combinational from req and last_grant
// last_grant remembers the most recent winner; on contention the other
// requester wins. It resets to 1 so requester 0 wins the first contention.
module rr_arbiter2
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last_grant);
        gnt[1] = req[1] & (~req[0] | ~last_grant);
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (|gnt)
            last_grant <= gnt[REQ_MEM];
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register file's single write port between
// the execute (req 0) and load/memory (req 1) writeback requesters and keeps
// a per-register busy scoreboard for WAW stalls.
//   clk, rst                      - clock, synchronous active-high reset
//   wbK_valid/rd/data, wbK_ready  - writeback requester K (transfer on valid&ready)
//   issue_valid/rd, issue_ready   - issue handshake; acceptance marks rd busy
//   busy[NREG-1:0]                - scoreboard, bit i = write to reg i pending
//   rf_wen/rf_wsel/rf_wdata       - registered write to the register file
module regfile_wb_scheduler
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int NREG = core_pkg::NREG,
    localparam int SELW = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb0_valid,
    input  logic [SELW-1:0]  wb0_rd,
    input  logic [XLEN-1:0]  wb0_data,
    output logic             wb0_ready,
    input  logic             wb1_valid,
    input  logic [SELW-1:0]  wb1_rd,
    input  logic [XLEN-1:0]  wb1_data,
    output logic             wb1_ready,
    input  logic             issue_valid,
    input  logic [SELW-1:0]  issue_rd,
    output logic             issue_ready,
    output logic [NREG-1:0]  busy,
    output logic             rf_wen,
    output logic [SELW-1:0]  rf_wsel,
    output logic [XLEN-1:0]  rf_wdata
);

    logic [1:0]      req, gnt;
    logic            any_gnt;
    logic [SELW-1:0] win_rd;
    logic [XLEN-1:0] win_data;
    logic            issue_set;
    logic [NREG-1:0] busy_q, busy_d;

    // Masking requests during reset keeps the readies low without a
    // separate output gate.
    assign req = {wb1_valid & ~rst, wb0_valid & ~rst};

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign wb0_ready = gnt[REQ_EXEC];
    assign wb1_ready = gnt[REQ_MEM];
    assign any_gnt   = |gnt;
    assign win_rd    = gnt[REQ_MEM] ? wb1_rd   : wb0_rd;
    assign win_data  = gnt[REQ_MEM] ? wb1_data : wb0_data;

    // No bypass: a clear landing this cycle is only seen next cycle.
    // busy_q[0] is always 0, so rd=0 always issues.
    assign issue_ready = ~rst & ~busy_q[issue_rd];
    assign issue_set   = issue_valid & issue_ready & (issue_rd != '0);

    // Clear first, then set, so a same-register set overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (any_gnt)
            busy_d[win_rd] = 1'b0;
        if (issue_set)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            rf_wen   <= 1'b0;
            rf_wsel  <= '0;
            rf_wdata <= '0;
        end else begin
            busy_q <= busy_d;
            // Writes to x0 are consumed but never reach the register file.
            rf_wen <= any_gnt & (win_rd != '0);
            if (any_gnt) begin
                rf_wsel  <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0_valid, wb1_valid, issue_valid;
    logic [4:0]  wb0_rd, wb1_rd, issue_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready, issue_ready;
    logic [31:0] busy;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .busy(busy), .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata)
    );

    // Inputs change and outputs are sampled 1 time unit after the posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb0_valid = 1'b1; wb0_rd = 5'd4; wb0_data = 32'h44;
        wb1_valid = 1'b1; wb1_rd = 5'd6; wb1_data = 32'h66;
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        tick();
        checks++;
        if ({wb0_ready, wb1_ready, issue_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies got %b exp 000", {wb0_ready, wb1_ready, issue_ready});
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy got %h exp 0", busy);
        end
        checks++;
        if ({rf_wen, rf_wsel, rf_wdata} !== 38'h0) begin
            errors++;
            $display("FAIL reset_rf got wen=%b sel=%0d data=%h exp all 0", rf_wen, rf_wsel, rf_wdata);
        end
    endtask

    task automatic test_contention();
        wb0_rd = 5'd1; wb0_data = 32'h11;
        wb1_rd = 5'd2; wb1_data = 32'h22;
        issue_valid = 1'b0;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] eg;
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({wb1_ready, wb0_ready} !== eg) begin
                errors++;
                $display("FAIL contention_gnt[%0d] got %b exp %b", i, {wb1_ready, wb0_ready}, eg);
            end
            tick();
            checks++;
            if (rf_wen !== 1'b1 || rf_wsel !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
                errors++;
                $display("FAIL contention_wsel[%0d] got wen=%b sel=%0d exp wen=1 sel=%0d",
                         i, rf_wen, rf_wsel, (i % 2 == 0) ? 1 : 2);
            end
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
    endtask

    task automatic test_single_write();
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_issue_ready got %b exp 1", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy !== 32'h20) begin
            errors++;
            $display("FAIL single_busy_set got %h exp 00000020", busy);
        end
        tick();
        checks++;
        if (busy[5] !== 1'b1 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy5=%b wen=%b exp busy5=1 wen=0", busy[5], rf_wen);
        end
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (wb0_ready !== 1'b1 || busy[5] !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got ready=%b busy5=%b exp 1 1", wb0_ready, busy[5]);
        end
        tick();
        wb0_valid = 1'b0;
        checks++;
        if (rf_wen !== 1'b1 || rf_wsel !== 5'd5 || rf_wdata !== 32'hDEADBEEF || busy[5] !== 1'b0) begin
            errors++;
            $display("FAIL single_write got wen=%b sel=%0d data=%h busy5=%b exp 1 5 deadbeef 0",
                     rf_wen, rf_wsel, rf_wdata, busy[5]);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_wsel !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_hold got wen=%b sel=%0d data=%h exp 0 5 deadbeef", rf_wen, rf_wsel, rf_wdata);
        end
    endtask

    task automatic test_x0();
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234;
        #1;
        checks++;
        if (wb1_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready got %b exp 1", wb1_ready);
        end
        tick();
        wb1_valid = 1'b0;
        checks++;
        if (rf_wen !== 1'b0 || rf_wsel !== 5'd0 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL x0_write got wen=%b sel=%0d data=%h exp 0 0 1234", rf_wen, rf_wsel, rf_wdata);
        end
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_issue_ready got %b exp 1", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL x0_busy got %h exp 0", busy);
        end
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (issue_ready !== 1'b0) begin
                errors++;
                $display("FAIL waw_stall[%0d] got %b exp 0", i, issue_ready);
            end
            tick();
        end
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h77;
        #1;
        checks++;
        if (issue_ready !== 1'b0 || wb1_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_grant_cycle got issue_ready=%b wb1_ready=%b exp 0 1", issue_ready, wb1_ready);
        end
        tick();
        wb1_valid = 1'b0;
        checks++;
        if (issue_ready !== 1'b1 || busy[7] !== 1'b0) begin
            errors++;
            $display("FAIL waw_release got issue_ready=%b busy7=%b exp 1 0", issue_ready, busy[7]);
        end
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy !== 32'h80) begin
            errors++;
            $display("FAIL waw_reissue got %h exp 00000080", busy);
        end
    endtask

    task automatic test_set_wins();
        issue_valid = 1'b1; issue_rd = 5'd9;
        wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h99;
        tick();
        issue_valid = 1'b0; wb0_valid = 1'b0;
        checks++;
        if (busy !== 32'h280) begin
            errors++;
            $display("FAIL set_wins got %h exp 00000280", busy);
        end
    endtask

    task automatic test_reset_mid();
        // Grant req 0 alone so last_grant points at req 0 before the reset.
        issue_valid = 1'b1; issue_rd = 5'd3;
        wb0_valid = 1'b1; wb0_rd = 5'd12; wb0_data = 32'hC;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy[3] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy3 got %b exp 1", busy[3]);
        end
        wb0_rd = 5'd10; wb0_data = 32'hA;
        wb1_valid = 1'b1; wb1_rd = 5'd11; wb1_data = 32'hB;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 32'h0 || rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%h wen=%b exp 0 0", busy, rf_wen);
        end
        checks++;
        if ({wb1_ready, wb0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_first_gnt got %b exp 01", {wb1_ready, wb0_ready});
        end
        tick();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        checks++;
        if (rf_wen !== 1'b1 || rf_wsel !== 5'd10 || rf_wdata !== 32'hA) begin
            errors++;
            $display("FAIL mid_write got wen=%b sel=%0d data=%h exp 1 10 a", rf_wen, rf_wsel, rf_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_x0();
        test_waw();
        test_set_wins();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
